ctrlport_cmd_initiator: RTL and testbench
=========================================

# ctrlport_cmd_initiator

CtrlPort master that converts a command stream (read/write, address, data) into single-transaction CtrlPort requests. It waits for the responder's acknowledgement with a bounded timeout and returns the read data or write completion on a response stream. It drives the register file of an RFNoC user block, such as the spectral-inversion control registers, from a local sequencer or test harness. It is the initiator end of the CtrlPort request/ack interface.

## Interface
- TIMEOUT, 64: maximum cycles to wait for `resp_ack` after a request strobe; legal range 1..65535.
- ERR_DATA, 32'hDEADBEEF: value returned in `m_rsp_data` on timeout.

- ctrlport_clk  in  1  sole clock; all logic on rising edge.
- ctrlport_rst_n  in  1  asynchronous, active-low reset.
- s_cmd_valid  in  1  command valid.
- s_cmd_ready  out  1  command accepted when valid&ready.
- s_cmd_wr  in  1  1 = write, 0 = read.
- s_cmd_addr  in  20  register byte address.
- s_cmd_data  in  32  write data; ignored for reads.
- m_ctrlport_req_wr  out  1  one-cycle write strobe.
- m_ctrlport_req_rd  out  1  one-cycle read strobe.
- m_ctrlport_req_addr  out  20  request address.
- m_ctrlport_req_data  out  32  request write data.
- m_ctrlport_resp_ack  in  1  responder acknowledge (one-cycle pulse).
- m_ctrlport_resp_data  in  32  read data, valid with ack.
- m_rsp_valid  out  1  response valid.
- m_rsp_ready  in  1  response consumed when valid&ready.
- m_rsp_data  out  32  read data: 0 for writes, ERR_DATA on timeout.
- m_rsp_timeout  out  1  transaction timed out.
- m_rsp_wr  out  1  echo of command type.
- stat_xact_count  out  32  completed transactions (acked or timed out); wraps.
- stat_timeout_count  out  16  timed-out transactions; saturates at 16'hFFFF.
- stat_stray_ack_count  out  16  acks received outside WAIT; saturates.

## Operation
- States:
  - IDLE: `s_cmd_ready` = 1. On valid&ready, latch wr/addr/data and go to REQ.
  - REQ: assert `req_wr` (if wr) or `req_rd` (if rd) for exactly this cycle. Clear the wait counter and go to WAIT.
  - WAIT: increment the wait counter each cycle.
    - On ack, capture `resp_data` (reads) or 0 (writes), clear timeout, go to RESP.
    - Else, when the counter reaches TIMEOUT, load ERR_DATA, set timeout, go to RESP.
  - RESP: `m_rsp_valid` = 1. On `m_rsp_ready`, go to IDLE.
- An ack in the same WAIT cycle that the counter reaches TIMEOUT is a success; the ack wins.
- Acks in IDLE, REQ or RESP are ignored for data, including late acks after a timeout. Each increments `stat_stray_ack_count`.
- `req_addr` and `req_data` hold the latched values from REQ until the next command is latched. Outside of a command they are 0 after reset.
- `req_wr` and `req_rd` are never high simultaneously and are never high outside REQ.
- `stat_xact_count` increments on the RESP→IDLE transition. `stat_timeout_count` increments on the same transition when timeout = 1.
- Response fields are stable while `m_rsp_valid` = 1 and `m_rsp_ready` = 0.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - state IDLE
  - `s_cmd_ready` = 1
  - both strobes 0
  - `req_addr`, `req_data` = 0
  - `m_rsp_valid` = 0, `m_rsp_data` = 0, `m_rsp_timeout` = 0, `m_rsp_wr` = 0
  - all stat counters = 0
- Reset mid-transaction aborts it. No response is produced. A later ack is counted as stray.
- Command accepted at cycle N → strobe high at N+1 (cycle S).
- Ack at cycle S+k (1 ≤ k ≤ TIMEOUT) → `m_rsp_valid` high at S+k+1.
- No ack by S+TIMEOUT → `m_rsp_valid` high at S+TIMEOUT+1 with `m_rsp_timeout` = 1.
- Throughput: with a registered responder (k = 1) and `m_rsp_ready` held high, the minimum command-to-command period is 4 cycles (IDLE, REQ, WAIT, RESP).
- `s_cmd_ready` is low from N+1 until the cycle after the response handshake.

## Test plan
- Write then read: write addr 0x08, data 0x00002000; responder acks at S+1 → response at S+2 with data 0, timeout 0, wr 1. Read 0x08 → `m_rsp_data` = 0x00002000.
- Timeout: TIMEOUT = 4, responder never acks → response at S+5 with data 0xDEADBEEF, timeout = 1, `stat_timeout_count` = 1. An ack injected at S+7 → `stat_stray_ack_count` = 1, no second response.
- Ack on boundary: TIMEOUT = 4, ack at S+4 with data 0x12345678 → timeout = 0, data 0x12345678.
- Backpressure: hold `m_rsp_ready` = 0 for 10 cycles → `m_rsp_valid` and data held stable, `s_cmd_ready` = 0, no strobes. Release → IDLE next cycle.
- Reset mid-WAIT: deassert `ctrlport_rst_n` two cycles after a read strobe → all outputs reach reset values immediately. After release, a new command completes normally.
- Back-to-back: 100 random commands with a random-latency responder (1..TIMEOUT) and random `m_rsp_ready` → responses in order, all data matches the model, `stat_xact_count` = 100.

Source files
------------

// File: rtl/ctrlport_cmd_initiator.sv
// CtrlPort initiator: turns a command stream into single CtrlPort requests,
// waits for the ack with a bounded timeout and returns a response beat.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | s_cmd_ready high, waiting for a command
// REQ   | one-cycle read or write strobe, wait counter cleared
// WAIT  | counting cycles until resp_ack or TIMEOUT
// RESP  | m_rsp_valid high until m_rsp_ready
module ctrlport_cmd_initiator #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        ctrlport_clk,
  input  logic        ctrlport_rst_n,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  input  logic        s_cmd_wr,
  input  logic [19:0] s_cmd_addr,
  input  logic [31:0] s_cmd_data,
  output logic        m_ctrlport_req_wr,
  output logic        m_ctrlport_req_rd,
  output logic [19:0] m_ctrlport_req_addr,
  output logic [31:0] m_ctrlport_req_data,
  input  logic        m_ctrlport_resp_ack,
  input  logic [31:0] m_ctrlport_resp_data,
  output logic        m_rsp_valid,
  input  logic        m_rsp_ready,
  output logic [31:0] m_rsp_data,
  output logic        m_rsp_timeout,
  output logic        m_rsp_wr,
  output logic [31:0] stat_xact_count,
  output logic [15:0] stat_timeout_count,
  output logic [15:0] stat_stray_ack_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

  // The counter holds (cycles spent in WAIT - 1), so the last allowed cycle is TIMEOUT-1.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        req_wr_q, req_wr_d;
  logic        req_rd_q, req_rd_d;
  logic [19:0] req_addr_q, req_addr_d;
  logic [31:0] req_data_q, req_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        rsp_wr_q, rsp_wr_d;
  logic [31:0] xact_cnt_q, xact_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [15:0] stray_cnt_q, stray_cnt_d;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    cmd_wr_d      = cmd_wr_q;
    cmd_ready_d   = cmd_ready_q;
    req_wr_d      = 1'b0;
    req_rd_d      = 1'b0;
    req_addr_d    = req_addr_q;
    req_data_d    = req_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_wr_d      = rsp_wr_q;
    xact_cnt_d    = xact_cnt_q;
    to_cnt_d      = to_cnt_q;
    stray_cnt_d   = stray_cnt_q;

    // Any ack we are not waiting for carries no data, late ones after a timeout included.
    if (m_ctrlport_resp_ack && (state_q != ST_WAIT) && (stray_cnt_q != 16'hFFFF)) begin
      stray_cnt_d = stray_cnt_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_cmd_valid) begin
          cmd_wr_d    = s_cmd_wr;
          req_addr_d  = s_cmd_addr;
          req_data_d  = s_cmd_data;
          req_wr_d    = s_cmd_wr;
          req_rd_d    = ~s_cmd_wr;
          cmd_ready_d = 1'b0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        wait_cnt_d = 16'd0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (m_ctrlport_resp_ack) begin
          rsp_data_d    = cmd_wr_q ? 32'd0 : m_ctrlport_resp_data;
          rsp_timeout_d = 1'b0;
          rsp_wr_d      = cmd_wr_q;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          rsp_data_d    = ERR_DATA;
          rsp_timeout_d = 1'b1;
          rsp_wr_d      = cmd_wr_q;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          xact_cnt_d  = xact_cnt_q + 32'd1;
          if (rsp_timeout_q && (to_cnt_q != 16'hFFFF)) begin
            to_cnt_d = to_cnt_q + 16'd1;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= 16'd0;
      cmd_wr_q      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      req_wr_q      <= 1'b0;
      req_rd_q      <= 1'b0;
      req_addr_q    <= 20'd0;
      req_data_q    <= 32'd0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'd0;
      rsp_timeout_q <= 1'b0;
      rsp_wr_q      <= 1'b0;
      xact_cnt_q    <= 32'd0;
      to_cnt_q      <= 16'd0;
      stray_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_wr_q      <= cmd_wr_d;
      cmd_ready_q   <= cmd_ready_d;
      req_wr_q      <= req_wr_d;
      req_rd_q      <= req_rd_d;
      req_addr_q    <= req_addr_d;
      req_data_q    <= req_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_wr_q      <= rsp_wr_d;
      xact_cnt_q    <= xact_cnt_d;
      to_cnt_q      <= to_cnt_d;
      stray_cnt_q   <= stray_cnt_d;
    end
  end

  assign s_cmd_ready          = cmd_ready_q;
  assign m_ctrlport_req_wr    = req_wr_q;
  assign m_ctrlport_req_rd    = req_rd_q;
  assign m_ctrlport_req_addr  = req_addr_q;
  assign m_ctrlport_req_data  = req_data_q;
  assign m_rsp_valid          = rsp_valid_q;
  assign m_rsp_data           = rsp_data_q;
  assign m_rsp_timeout        = rsp_timeout_q;
  assign m_rsp_wr             = rsp_wr_q;
  assign stat_xact_count      = xact_cnt_q;
  assign stat_timeout_count   = to_cnt_q;
  assign stat_stray_ack_count = stray_cnt_q;

endmodule

// File: tb/tb_ctrlport_cmd_initiator.sv
// Bench for ctrlport_cmd_initiator: transaction-timeline model checked every cycle,
// directed scenarios with literal expectations, then 100 randomized commands.
module tb_ctrlport_cmd_initiator;
  localparam int TO = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic        s_cmd_wr = 1'b0;
  logic [19:0] s_cmd_addr = 20'd0;
  logic [31:0] s_cmd_data = 32'd0;
  logic        m_ctrlport_req_wr, m_ctrlport_req_rd;
  logic [19:0] m_ctrlport_req_addr;
  logic [31:0] m_ctrlport_req_data;
  logic        m_ctrlport_resp_ack;
  logic [31:0] resp_data_r = 32'd0;
  logic        resp_ack_r = 1'b0;
  logic        stray_ack = 1'b0;
  logic        m_rsp_valid;
  logic        m_rsp_ready = 1'b0;
  logic [31:0] m_rsp_data;
  logic        m_rsp_timeout, m_rsp_wr;
  logic [31:0] stat_xact_count;
  logic [15:0] stat_timeout_count, stat_stray_ack_count;

  assign m_ctrlport_resp_ack = resp_ack_r | stray_ack;

  ctrlport_cmd_initiator #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .ctrlport_clk         (clk),
    .ctrlport_rst_n       (rst_n),
    .s_cmd_valid          (s_cmd_valid),
    .s_cmd_ready          (s_cmd_ready),
    .s_cmd_wr             (s_cmd_wr),
    .s_cmd_addr           (s_cmd_addr),
    .s_cmd_data           (s_cmd_data),
    .m_ctrlport_req_wr    (m_ctrlport_req_wr),
    .m_ctrlport_req_rd    (m_ctrlport_req_rd),
    .m_ctrlport_req_addr  (m_ctrlport_req_addr),
    .m_ctrlport_req_data  (m_ctrlport_req_data),
    .m_ctrlport_resp_ack  (m_ctrlport_resp_ack),
    .m_ctrlport_resp_data (resp_data_r),
    .m_rsp_valid          (m_rsp_valid),
    .m_rsp_ready          (m_rsp_ready),
    .m_rsp_data           (m_rsp_data),
    .m_rsp_timeout        (m_rsp_timeout),
    .m_rsp_wr             (m_rsp_wr),
    .stat_xact_count      (stat_xact_count),
    .stat_timeout_count   (stat_timeout_count),
    .stat_stray_ack_count (stat_stray_ack_count)
  );

  always #5 clk = ~clk;

  longint cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int checks = 0;
  int errors = 0;
  int lat = 1;  // responder latency for the next strobe; 0 = never ack
  logic [31:0] mem [logic [19:0]];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endfunction

  function automatic void check_reset();
    chk("rst_cmd_ready", 32'(s_cmd_ready), 32'd1);
    chk("rst_req_wr", 32'(m_ctrlport_req_wr), 32'd0);
    chk("rst_req_rd", 32'(m_ctrlport_req_rd), 32'd0);
    chk("rst_req_addr", 32'(m_ctrlport_req_addr), 32'd0);
    chk("rst_req_data", m_ctrlport_req_data, 32'd0);
    chk("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("rst_rsp_data", m_rsp_data, 32'd0);
    chk("rst_rsp_timeout", 32'(m_rsp_timeout), 32'd0);
    chk("rst_rsp_wr", 32'(m_rsp_wr), 32'd0);
    chk("rst_xact", stat_xact_count, 32'd0);
    chk("rst_to_cnt", 32'(stat_timeout_count), 32'd0);
    chk("rst_stray", 32'(stat_stray_ack_count), 32'd0);
  endfunction

  // Responder: acks lat cycles after the strobe, backed by a small register map.
  initial begin : responder
    int cnt;
    logic p_wr;
    logic [19:0] p_addr;
    logic [31:0] p_data;
    cnt = 0;
    p_wr = 1'b0;
    p_addr = 20'd0;
    p_data = 32'd0;
    forever begin
      @(posedge clk); #1;
      resp_ack_r = 1'b0;
      if (!rst_n) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            resp_ack_r = 1'b1;
            if (p_wr) begin
              mem[p_addr] = p_data;
              resp_data_r = $urandom;
            end else begin
              resp_data_r = mem.exists(p_addr) ? mem[p_addr] : 32'd0;
            end
          end
        end
        if (m_ctrlport_req_wr || m_ctrlport_req_rd) begin
          p_wr = m_ctrlport_req_wr;
          p_addr = m_ctrlport_req_addr;
          p_data = m_ctrlport_req_data;
          cnt = lat;
        end
      end
    end
  end

  // Timeline model: a command accepted in cycle c strobes in c+1; the response is due the
  // cycle after the first ack in the window S+1..S+TO, or after S+TO when none arrives.
  logic        m_busy = 1'b0, m_wait = 1'b0, m_dec = 1'b0;
  logic        c_wr = 1'b0, e_to = 1'b0, e_wr = 1'b0;
  longint      strobe_c = -1, rsp_c = 0;
  logic [19:0] e_addr = 20'd0;
  logic [31:0] e_wdata = 32'd0, e_data = 32'd0, e_xact = 32'd0;
  logic [15:0] e_tocnt = 16'd0, e_stray = 16'd0;

  always @(negedge clk) begin : cmp
    logic exp_v;
    if (!rst_n) begin
      check_reset();
      m_busy = 1'b0; m_wait = 1'b0; m_dec = 1'b0; strobe_c = -1;
      e_addr = 20'd0; e_wdata = 32'd0; e_xact = 32'd0; e_tocnt = 16'd0; e_stray = 16'd0;
    end else begin
      exp_v = m_busy && m_dec && (cyc_n >= rsp_c);
      chk("cmd_ready", 32'(s_cmd_ready), 32'(!m_busy));
      chk("req_wr", 32'(m_ctrlport_req_wr), 32'((cyc_n == strobe_c) && c_wr));
      chk("req_rd", 32'(m_ctrlport_req_rd), 32'((cyc_n == strobe_c) && !c_wr));
      chk("req_addr", 32'(m_ctrlport_req_addr), 32'(e_addr));
      chk("req_data", m_ctrlport_req_data, e_wdata);
      chk("rsp_valid", 32'(m_rsp_valid), 32'(exp_v));
      if (exp_v) begin
        chk("rsp_data", m_rsp_data, e_data);
        chk("rsp_timeout", 32'(m_rsp_timeout), 32'(e_to));
        chk("rsp_wr", 32'(m_rsp_wr), 32'(e_wr));
      end
      chk("xact_count", stat_xact_count, e_xact);
      chk("timeout_count", 32'(stat_timeout_count), 32'(e_tocnt));
      chk("stray_count", 32'(stat_stray_ack_count), 32'(e_stray));

      if (s_cmd_valid && !m_busy) begin
        m_busy = 1'b1; m_dec = 1'b0; m_wait = 1'b0;
        strobe_c = cyc_n + 1;
        c_wr = s_cmd_wr; e_addr = s_cmd_addr; e_wdata = s_cmd_data;
      end
      if (m_ctrlport_resp_ack) begin
        if (m_wait) begin
          m_wait = 1'b0; m_dec = 1'b1; rsp_c = cyc_n + 1;
          e_data = c_wr ? 32'd0 : resp_data_r; e_to = 1'b0; e_wr = c_wr;
        end else if (e_stray != 16'hFFFF) e_stray++;
      end else if (m_wait && (cyc_n == strobe_c + TO)) begin
        m_wait = 1'b0; m_dec = 1'b1; rsp_c = cyc_n + 1;
        e_data = ERR; e_to = 1'b1; e_wr = c_wr;
      end
      if (m_busy && (cyc_n == strobe_c)) m_wait = 1'b1;
      if (exp_v && m_rsp_ready) begin
        e_xact++;
        if (e_to && (e_tocnt != 16'hFFFF)) e_tocnt++;
        m_busy = 1'b0; m_dec = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Returns in the strobe cycle S.
  task automatic send_cmd(input logic wr, input logic [19:0] a, input logic [31:0] d);
    int n;
    n = 0;
    s_cmd_valid = 1'b1; s_cmd_wr = wr; s_cmd_addr = a; s_cmd_data = d;
    forever begin
      @(negedge clk);
      if (s_cmd_ready) break;
      n++;
      if (n > 40) begin
        checks++; errors++;
        $display("FAIL cmd_accept: not accepted within 40 cycles (cycle %0d)", cyc_n);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
  endtask

  // Called in cycle S; checks latency to m_rsp_valid and the literal response fields.
  task automatic expect_rsp(input int exp_n, input logic [31:0] d, input logic to, input logic wr);
    int n;
    n = 0;
    while (!m_rsp_valid && n < 40) begin
      cyc();
      n++;
    end
    chk("lit_rsp_latency", 32'(n), 32'(exp_n));
    chk("lit_rsp_data", m_rsp_data, d);
    chk("lit_rsp_timeout", 32'(m_rsp_timeout), 32'(to));
    chk("lit_rsp_wr", 32'(m_rsp_wr), 32'(wr));
    if (m_rsp_ready) cyc();
  endtask

  task automatic wait_hs();
    int n;
    n = 0;
    forever begin
      m_rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (m_rsp_valid && m_rsp_ready) break;
      n++;
      if (n > 60) begin
        checks++; errors++;
        $display("FAIL rsp_handshake: no response within 60 cycles (cycle %0d)", cyc_n);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 check_reset();
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    longint t1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    chk("lit_ready_after_reset", 32'(s_cmd_ready), 32'd1);
    m_rsp_ready = 1'b1;

    // Write then read back.
    lat = 1;
    send_cmd(1'b1, 20'h00008, 32'h00002000);
    expect_rsp(2, 32'd0, 1'b0, 1'b1);
    send_cmd(1'b0, 20'h00008, 32'hFFFFFFFF);
    expect_rsp(2, 32'h00002000, 1'b0, 1'b0);

    // Timeout, then a late ack that must only bump the stray counter.
    lat = 0;
    send_cmd(1'b0, 20'h00008, 32'd0);
    expect_rsp(5, ERR, 1'b1, 1'b0);
    chk("lit_timeout_count", 32'(stat_timeout_count), 32'd1);
    cyc();
    stray_ack = 1'b1;
    cyc();
    stray_ack = 1'b0;
    chk("lit_stray_late", 32'(stat_stray_ack_count), 32'd1);
    repeat (3) begin
      cyc();
      chk("lit_no_second_rsp", 32'(m_rsp_valid), 32'd0);
    end
    chk("lit_xact_3", stat_xact_count, 32'd3);

    // Ack on the last allowed cycle wins over the timeout.
    lat = 1;
    send_cmd(1'b1, 20'h00010, 32'h12345678);
    expect_rsp(2, 32'd0, 1'b0, 1'b1);
    lat = TO;
    send_cmd(1'b0, 20'h00010, 32'd0);
    expect_rsp(TO + 1, 32'h12345678, 1'b0, 1'b0);

    // Minimum command-to-command period.
    lat = 1;
    send_cmd(1'b1, 20'h00004, 32'h0000CAFE);
    t1 = cyc_n;
    expect_rsp(2, 32'd0, 1'b0, 1'b1);
    send_cmd(1'b1, 20'h0000C, 32'h0000BEEF);
    chk("lit_period", 32'(cyc_n - t1), 32'd4);
    expect_rsp(2, 32'd0, 1'b0, 1'b1);

    // Backpressure holds the response and blocks new commands.
    m_rsp_ready = 1'b0;
    lat = 2;
    send_cmd(1'b0, 20'h00008, 32'd0);
    expect_rsp(3, 32'h00002000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("lit_bp_valid", 32'(m_rsp_valid), 32'd1);
      chk("lit_bp_data", m_rsp_data, 32'h00002000);
      chk("lit_bp_cmd_ready", 32'(s_cmd_ready), 32'd0);
      chk("lit_bp_strobes", 32'(m_ctrlport_req_wr | m_ctrlport_req_rd), 32'd0);
    end
    m_rsp_ready = 1'b1;
    cyc();
    chk("lit_bp_release_ready", 32'(s_cmd_ready), 32'd1);
    chk("lit_bp_release_valid", 32'(m_rsp_valid), 32'd0);
    chk("lit_xact_8", stat_xact_count, 32'd8);

    // Reset two cycles after a read strobe, then recover.
    lat = 0;
    send_cmd(1'b0, 20'h00004, 32'd0);
    cyc(); cyc();
    do_reset();
    stray_ack = 1'b1;
    cyc();
    stray_ack = 1'b0;
    cyc();
    chk("lit_stray_after_reset", 32'(stat_stray_ack_count), 32'd1);
    chk("lit_no_rsp_after_reset", 32'(m_rsp_valid), 32'd0);
    lat = 2;
    send_cmd(1'b1, 20'h00020, 32'h0000A5A5);
    expect_rsp(3, 32'd0, 1'b0, 1'b1);
    chk("lit_xact_after_reset", stat_xact_count, 32'd1);

    // Randomized back-to-back traffic.
    cyc();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      lat = $urandom_range(1, TO);
      send_cmd(1'($urandom_range(0, 1)), {16'd0, 2'($urandom_range(0, 3)), 2'b00}, $urandom);
      wait_hs();
      if ($urandom_range(0, 3) == 0) cyc();
    end
    m_rsp_ready = 1'b0;
    cyc();
    chk("lit_random_xact", stat_xact_count, 32'd100);
    chk("lit_random_timeouts", 32'(stat_timeout_count), 32'd0);
    chk("lit_random_strays", 32'(stat_stray_ack_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
